i2c_master_wr_ctrl: RTL and testbench
=====================================

# i2c_master_wr_ctrl

Sequencer for the I2C master's write path: accepts a write request (7-bit address plus 0–15 data bytes), generates START, address byte, data bytes, ACK checks and STOP on SCL/SDA. It owns an internal parallel-load MSB-first byte shifter and fetches each data byte from the host through a valid/ready handshake. It sits between the host command interface and the open-drain pad cells.

## Interface
- CLK_DIV, 4: Clk cycles per SCL quarter-period; legal range ≥ 2.
- Clk  in  1  system clock
- Rst  in  1  reset, asynchronous, active-low
- Start  in  1  request pulse; sampled only while Busy=0
- Addr  in  7  slave address; latched on accepted Start
- Len  in  4  number of data bytes; latched on accepted Start; 0 = address-only
- Data_in  in  8  next data byte
- Data_valid  in  1  Data_in valid
- Data_ready  out  1  controller is waiting for a byte; transfer occurs when Data_valid && Data_ready
- Sda_i  in  1  sampled SDA line
- Sda_o  out  1  0 = pull SDA low, 1 = release
- Scl_o  out  1  0 = pull SCL low, 1 = release
- Busy  out  1  transaction in progress
- Done  out  1  one-cycle pulse when the transaction ends
- Nack  out  1  last transaction ended on a NACK; held until the next accepted Start

## Operation
- States: IDLE, START, ADDR, ACK_A, WAIT_D, DATA, ACK_D, STOP.
- Every state except IDLE and WAIT_D consists of 4-quarter cells (q0..q3), each CLK_DIV Clk long. Counters: divider, 2-bit quarter, 3-bit bit index, 4-bit bytes remaining.
- Bit cell (ADDR, DATA, ACK_*):
  - Scl_o = 0 in q0 and q3, 1 in q1 and q2.
  - Sda_o is updated at entry to q0 and held through q3.
- START cell:
  - q0–q1: Scl_o=1, Sda_o=1.
  - q2: Sda_o=0 with Scl_o=1.
  - q3: Sda_o=0, Scl_o=0.
- STOP cell:
  - q0: Sda_o=0, Scl_o=0.
  - q1: Scl_o=1.
  - q2–q3: Sda_o=1, Scl_o=1.
- IDLE → START on Start && !Busy. This latches Addr and Len, clears Nack, and loads the shifter with {Addr,1'b0} (write bit).
- START → ADDR: 8 bit cells, MSB first.
- ACK_A / ACK_D:
  - Sda_o=1 (released).
  - Sda_i is sampled on the last Clk of q1.
  - On sample 1: set Nack and go to STOP after the cell.
  - On sample 0: if bytes remaining = 0, go to STOP; otherwise go to WAIT_D.
- WAIT_D: Scl_o=0, Sda_o unchanged, Data_ready=1. On handshake: load the shifter, decrement bytes remaining, go to DATA. The host can stall indefinitely (master-side stretch).
- DATA → ACK_D after 8 cells.
- STOP → IDLE. Done=1 for exactly one cycle in the first IDLE cycle; Busy=0 in that same cycle.
- Start while Busy=1 is ignored (not queued).
- Data_valid outside WAIT_D is ignored; Data_ready is never asserted outside WAIT_D.
- Reset values: Sda_o=1, Scl_o=1, Busy=0, Done=0, Nack=0, Data_ready=0; state=IDLE; all counters 0.
- Rst low mid-transaction aborts immediately to the reset values. No STOP is generated; this behaviour is accepted.

## Timing
- Start accepted at edge t: Busy=1 and START q0 begin at t+1.
- SDA falling edge (START) at t+1+2·CLK_DIV.
- Transaction length without stalls: (8 + 36·(1+Len))·CLK_DIV clocks from t+1. Done pulses in the cycle immediately after.
- Each WAIT_D lasts ≥ 1 cycle: Data_ready rises in the first WAIT_D cycle, and DATA q0 begins the cycle after the handshake.
- Registered outputs only; no combinational path from inputs to outputs.

## Structure
- Shared package (i2c_pkg): state enum, address-byte write-bit constant (WR_BIT=0), quarter-phase encoding.
- One sub-module: i2c_byte_shifter. It provides an 8-bit parallel load, a shift-enable, an MSB output, and a bit-done flag. It is controlled by the FSM and has no internal counter.
- Divider, quarter counter and FSM stay in the top module.

## Test plan
- Addr=7'h50, Len=1, Data 8'hA5, slave ACKs everything, CLK_DIV=4 → SDA carries 0xA0 then 0xA5 around START/STOP; Done at t+1+320; Nack=0.
- Addr=7'h21, Len=0, slave NACKs the address → STOP right after ACK_A; Done pulse; Nack=1; Data_ready never asserted.
- Len=3, host delays Data_valid 50 cycles on byte 2 → Scl_o held 0 for the whole stall; byte bits are intact; total time extends by exactly the stall.
- NACK on data byte 1 of Len=3 → STOP follows; remaining bytes are not requested; Nack=1 until the next Start.
- Start pulsed while Busy → ignored; current transaction completes unchanged.
- Rst asserted in the middle of DATA → Sda_o=Scl_o=1 and Busy=0 asynchronously; a new Start afterwards runs normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master write path.
package i2c_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_WAIT_D,
    ST_DATA,
    ST_ACK_D,
    ST_STOP
  } state_e;

  // Quarter phases of one SCL cell.
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quarter_e;

  // R/W bit appended to the 7-bit address; this controller only writes.
  localparam logic WR_BIT = 1'b0;

  // SCL is released in the two middle quarters of a bit cell.
  function automatic logic scl_bit_cell(input quarter_e q);
    return (q == Q1) || (q == Q2);
  endfunction

endpackage

// File: rtl/i2c_byte_shifter.sv
// MSB-first byte shifter with a trailing sentinel bit that marks when all
// eight bits have been shifted out, so no counter is needed here.
module i2c_byte_shifter
  import i2c_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       load_en,
  input  logic [7:0] load_data,
  input  logic       shift_en,
  output logic       msb,
  output logic       bit_done
);

  logic [8:0] sh_q;
  logic [8:0] sh_d;

  // Load has priority over shift; the sentinel 1 follows the data bits.
  always_comb begin
    sh_d = sh_q;
    if (load_en) begin
      sh_d = {load_data, 1'b1};
    end else if (shift_en) begin
      sh_d = {sh_q[7:0], 1'b0};
    end
  end

  // Shift register storage.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb      = sh_q[8];
  assign bit_done = (sh_q[7:0] == 8'h00);

endmodule

// File: rtl/i2c_master_wr_ctrl.sv
// I2C master write sequencer: START, address byte, data bytes fetched from
// the host by valid/ready, ACK checks and STOP. All outputs are flops.
module i2c_master_wr_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [6:0] Addr,
  input  logic [3:0] Len,
  input  logic [7:0] Data_in,
  input  logic       Data_valid,
  output logic       Data_ready,
  input  logic       Sda_i,
  output logic       Sda_o,
  output logic       Scl_o,
  output logic       Busy,
  output logic       Done,
  output logic       Nack
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  quarter_e         quarter_q, quarter_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       bytes_q, bytes_d;
  logic             ack_q, ack_d;
  logic             nack_q, nack_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             sda_q, sda_d;
  logic             scl_q, scl_d;

  logic       tick;
  logic       cell_end;
  logic       start_acc;
  logic       hs;
  logic       early_wait;
  logic       new_cell;
  logic       sh_load;
  logic       sh_shift;
  logic [7:0] sh_data;
  logic       sh_msb;
  logic       sh_bit_done;

  assign tick      = (div_q == DIV_LAST);
  assign cell_end  = tick && (quarter_q == Q3);
  assign start_acc = Start && !busy_q;
  assign hs        = (state_q == ST_WAIT_D) && Data_valid && ready_q;

  // The mandatory WAIT_D cycle replaces the last Clk of the ACK cell, so a
  // byte the host supplies immediately keeps the nominal cell timing.
  assign early_wait = (quarter_q == Q3) && (div_q == DIV_PRE) && !ack_q && (bytes_q != 4'd0);

  assign sh_load  = start_acc || hs;
  assign sh_data  = start_acc ? {Addr, WR_BIT} : Data_in;
  assign sh_shift = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && tick && (quarter_q == Q0);

  i2c_byte_shifter u_shifter (
    .Clk       (Clk),
    .Rst       (Rst),
    .load_en   (sh_load),
    .load_data (sh_data),
    .shift_en  (sh_shift),
    .msb       (sh_msb),
    .bit_done  (sh_bit_done)
  );

  // Next-state logic: divider, quarter and bit counters, byte countdown and ACK sampling.
  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    quarter_d = tick ? quarter_e'(quarter_q + 2'd1) : quarter_q;
    bit_idx_d = bit_idx_q;
    bytes_d   = bytes_q;
    ack_d     = ack_q;
    nack_d    = nack_q;
    case (state_q)
      ST_IDLE: begin
        div_d     = '0;
        quarter_d = Q0;
        if (start_acc) begin
          state_d   = ST_START;
          bytes_d   = Len;
          nack_d    = 1'b0;
          ack_d     = 1'b0;
          bit_idx_d = 3'd0;
        end
      end
      ST_START: begin
        if (cell_end) begin
          state_d   = ST_ADDR;
          bit_idx_d = 3'd0;
        end
      end
      ST_ADDR, ST_DATA: begin
        if (cell_end) begin
          if ((bit_idx_q == 3'd7) && sh_bit_done) begin
            state_d   = (state_q == ST_ADDR) ? ST_ACK_A : ST_ACK_D;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_ACK_A, ST_ACK_D: begin
        if (tick && (quarter_q == Q1)) begin
          ack_d = Sda_i;
          if (Sda_i) begin
            nack_d = 1'b1;
          end
        end
        if (early_wait) begin
          state_d   = ST_WAIT_D;
          div_d     = '0;
          quarter_d = Q0;
        end else if (cell_end) begin
          state_d = ST_STOP;
        end
      end
      ST_WAIT_D: begin
        div_d     = '0;
        quarter_d = Q0;
        if (hs) begin
          state_d   = ST_DATA;
          bytes_d   = bytes_q - 4'd1;
          bit_idx_d = 3'd0;
        end
      end
      ST_STOP: begin
        if (cell_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values decoded from the upcoming state and quarter so the pins come straight from flops.
  always_comb begin
    new_cell = (state_d != state_q) || cell_end;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_q == ST_STOP) && (state_d == ST_IDLE);
    ready_d  = (state_d == ST_WAIT_D);
    sda_d    = sda_q;
    scl_d    = 1'b1;
    case (state_d)
      ST_IDLE: begin
        sda_d = 1'b1;
        scl_d = 1'b1;
      end
      ST_START: begin
        scl_d = (quarter_d != Q3);
        sda_d = (quarter_d == Q0) || (quarter_d == Q1);
      end
      ST_ADDR, ST_DATA: begin
        scl_d = scl_bit_cell(quarter_d);
        if (new_cell) begin
          sda_d = hs ? Data_in[7] : sh_msb;
        end
      end
      ST_ACK_A, ST_ACK_D: begin
        scl_d = scl_bit_cell(quarter_d);
        if (new_cell) begin
          sda_d = 1'b1;
        end
      end
      ST_WAIT_D: begin
        scl_d = 1'b0;
      end
      ST_STOP: begin
        scl_d = (quarter_d != Q0);
        sda_d = (quarter_d == Q2) || (quarter_d == Q3);
      end
      default: begin
        sda_d = 1'b1;
        scl_d = 1'b1;
      end
    endcase
  end

  // State, counter and output registers; reset releases both lines.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      quarter_q <= Q0;
      bit_idx_q <= 3'd0;
      bytes_q   <= 4'd0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      sda_q     <= 1'b1;
      scl_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      quarter_q <= quarter_d;
      bit_idx_q <= bit_idx_d;
      bytes_q   <= bytes_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      sda_q     <= sda_d;
      scl_q     <= scl_d;
    end
  end

  assign Sda_o      = sda_q;
  assign Scl_o      = scl_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Nack       = nack_q;
  assign Data_ready = ready_q;

endmodule

// File: tb/tb_i2c_master_wr_ctrl.sv
// Bench for i2c_master_wr_ctrl: an I2C bus monitor/slave decodes the pins and
// a host model feeds bytes; expectations come from transaction-level rules.
module tb_i2c_master_wr_ctrl;

  localparam int CLK_DIV = 4;
  localparam int HALF    = 5;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       start      = 1'b0;
  logic [6:0] addr       = '0;
  logic [3:0] len        = '0;
  logic [7:0] data_in    = '0;
  logic       data_valid = 1'b0;
  logic       sda_i      = 1'b1;
  logic       data_ready;
  logic       sda_o;
  logic       scl_o;
  logic       busy;
  logic       done;
  logic       nack;

  int checks   = 0;
  int failures = 0;

  int         nack_at    = -1;
  int         bit_cnt    = 0;
  int         stop_seen  = 0;
  logic [7:0] cur        = '0;
  logic       prev_scl   = 1'b1;
  logic       prev_sda   = 1'b1;
  logic [7:0] got_bytes[$];

  i2c_master_wr_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .Clk        (clk),
    .Rst        (rst_n),
    .Start      (start),
    .Addr       (addr),
    .Len        (len),
    .Data_in    (data_in),
    .Data_valid (data_valid),
    .Data_ready (data_ready),
    .Sda_i      (sda_i),
    .Sda_o      (sda_o),
    .Scl_o      (scl_o),
    .Busy       (busy),
    .Done       (done),
    .Nack       (nack)
  );

  always #HALF clk = ~clk;

  // Bus monitor and slave: decodes START/STOP and bytes, drives ACK or NACK on the ninth clock.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_i    = 1'b1;
      prev_scl = 1'b1;
      prev_sda = 1'b1;
    end else begin
      if (prev_scl && scl_o && prev_sda && !sda_o) begin
        bit_cnt = 0;
        cur     = '0;
        sda_i   = 1'b1;
      end else if (prev_scl && scl_o && !prev_sda && sda_o) begin
        stop_seen++;
      end else if (!prev_scl && scl_o) begin
        if ((bit_cnt % 9) < 8) begin
          cur = {cur[6:0], sda_o};
          if ((bit_cnt % 9) == 7) got_bytes.push_back(cur);
        end
        bit_cnt++;
      end else if (prev_scl && !scl_o) begin
        if ((bit_cnt % 9) == 8) sda_i = ((bit_cnt / 9) == nack_at);
        else sda_i = 1'b1;
      end
      prev_scl = scl_o;
      prev_sda = sda_o;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One write transaction. nk: -1 all ACK, 0 NACK address, j NACK data byte j-1.
  task automatic apply_stimulus(input logic [6:0] a, input int ln, input int nk, input logic [7:0] b0,
                                input int stall_byte, input int stall_len, input int poke_at, input int abort_at);
    logic [7:0] data[16];
    logic [7:0] exp_q[$];
    int n, bidx, wcnt, nb_data, exp_n, sda_fall, scl_bad, hs_cnt, stops0, limit;
    bit done_seen, aborted;
    for (int i = 0; i < 16; i++) data[i] = 8'($urandom);
    data[0] = b0;
    nack_at = nk;
    got_bytes.delete();
    stops0 = stop_seen;
    nb_data = (nk < 0) ? ln : nk;
    exp_q.push_back({a, 1'b0});
    for (int i = 0; i < nb_data; i++) exp_q.push_back(data[i]);
    exp_n = (8 + 36 * (1 + nb_data)) * CLK_DIV + ((stall_byte >= 0 && stall_byte < nb_data) ? stall_len : 0);
    limit = exp_n + 200;
    $display("[TB] txn addr=%h len=%0d nack_at=%0d stall=%0d@%0d", a, ln, nk, stall_len, stall_byte);

    @(negedge clk);
    addr  = a;
    len   = 4'(ln);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_output("busy_rise", busy, 1);
    check_output("nack_clr", nack, 0);

    n = 0; bidx = 0; wcnt = 0; sda_fall = -1; scl_bad = 0; hs_cnt = 0;
    done_seen = 0; aborted = 0;
    while (!done_seen && n < limit) begin
      if (sda_o == 1'b0 && sda_fall < 0) sda_fall = n;
      if (data_ready && scl_o) scl_bad++;
      if (data_valid) begin
        data_valid = 1'b0;
        bidx++;
        hs_cnt++;
        wcnt = 0;
      end else if (data_ready) begin
        if (wcnt >= ((bidx == stall_byte) ? stall_len : 0)) begin
          data_valid = 1'b1;
          data_in    = data[bidx];
        end else begin
          wcnt++;
        end
      end
      if (done) done_seen = 1;
      if (n == poke_at) begin
        start = 1'b1;
        addr  = ~a;
        len   = 4'hF;
      end else begin
        start = 1'b0;
      end
      if (n == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        check_output("abort_sda", sda_o, 1);
        check_output("abort_scl", scl_o, 1);
        check_output("abort_busy", busy, 0);
        check_output("abort_ready", data_ready, 0);
        data_valid = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        aborted = 1;
        break;
      end
      if (!done_seen) begin
        @(negedge clk);
        n++;
      end
    end

    if (!aborted) begin
      check_output("done_seen", done_seen, 1);
      if (done_seen) begin
        check_output("done_time", n, exp_n);
        check_output("busy_at_done", busy, 0);
        check_output("sda_start_fall", sda_fall, 2 * CLK_DIV);
        check_output("nack_flag", nack, (nk >= 0) ? 1 : 0);
        check_output("bytes_requested", hs_cnt, nb_data);
        check_output("scl_during_wait", scl_bad, 0);
        check_output("stop_count", stop_seen - stops0, 1);
        check_output("byte_count", got_bytes.size(), exp_q.size());
        if (got_bytes.size() == exp_q.size()) begin
          foreach (exp_q[i]) check_output($sformatf("byte%0d", i), got_bytes[i], exp_q[i]);
        end
        @(negedge clk);
        check_output("done_pulse", done, 0);
      end
    end
  endtask

  // Directed steps followed by a few randomized transactions.
  initial begin
    repeat (3) @(negedge clk);
    check_output("rst_sda", sda_o, 1);
    check_output("rst_scl", scl_o, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_nack", nack, 0);
    check_output("rst_ready", data_ready, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    apply_stimulus(7'h50, 1, -1, 8'hA5, -1, 0, -1, -1);
    apply_stimulus(7'h21, 0, 0, 8'h00, -1, 0, -1, -1);
    apply_stimulus(7'h3C, 3, -1, 8'h5A, 1, 50, -1, -1);
    apply_stimulus(7'h11, 3, 1, 8'hC3, -1, 0, -1, -1);
    repeat (20) @(negedge clk);
    check_output("nack_hold", nack, 1);
    apply_stimulus(7'h6E, 2, -1, 8'h81, -1, 0, 100, -1);
    apply_stimulus(7'h2B, 2, -1, 8'hF0, -1, 0, -1, 200);
    apply_stimulus(7'h2B, 2, -1, 8'h0F, -1, 0, -1, -1);

    for (int t = 0; t < 4; t++) begin
      int rl, rn;
      rl = int'($urandom_range(0, 4));
      rn = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rl)) : -1;
      apply_stimulus(7'($urandom), rl, rn, 8'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 10)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
